// File: rtl/prbs_pkg.sv
// prbs_pkg
// Shared definitions for the PRBS share arbiter slice:
//   - state_t       : arbiter FSM states (INIT, IDLE)
//   - DEFAULT_SEED  : default reset / recovery seed for a 4-bit LFSR
//   - DEFAULT_TAPS  : default feedback mask (x^4 + x^3 + 1, period 15)
//   - rr_search()   : round-robin winner search, returns index + found flag
// Optional feature macro used by the slice: PRBS_LOCKUP_GUARD_EN
package prbs_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    // Largest requester count the search function supports
    localparam int MAX_REQ = 8;

    localparam logic [3:0] DEFAULT_SEED = 4'b1000;
    localparam logic [3:0] DEFAULT_TAPS = 4'b1100;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Searches upward from ptr+1, wrapping modulo nreq; the first set bit wins.
    // The requester at ptr itself is checked last, which gives the
    // "served again only after everyone else" fairness.
    function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        rr_pick_t pick;
        int       cand;
        pick.found = 1'b0;
        pick.idx   = 3'd0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= nreq) begin
                cand = (int'(ptr) + i) % nreq;
                if (!pick.found && req[cand[2:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = cand[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/prbs_share_arbiter_lfsr_core.sv
// lfsr_core
// Fibonacci LFSR register shifting left with the feedback bit entering at
// bit 0: next = {q[WIDTH-2:0], ^(q & TAPS)}.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset, q <= SEED
//   load       : load load_value this cycle (wins over step)
//   load_value : value to load
//   step       : advance the LFSR one position
//   q          : current LFSR state
module lfsr_core
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= SEED;
        end else if (load) begin
            q <= load_value;
        end else if (step) begin
            q <= {q[WIDTH-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/prbs_share_arbiter.sv
// prbs_share_arbiter
// Shares one LFSR pseudo-random source among NREQ requesters with
// round-robin arbitration, at most one word granted per clock. The LFSR
// only advances on a cycle that issues a grant, so every granted word is
// distinct until the LFSR period wraps.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset
//   seed_load  : load seed_value into the LFSR (suppresses the grant)
//   seed_value : seed to load
//   req        : level requests, one bit per requester
//   gnt        : registered one-hot grant, valid for one cycle
//   rnd_data   : random word delivered with gnt, held otherwise
//   rnd_valid  : high exactly when gnt is non-zero
//   busy       : high while in INIT
//   lockup_err : sticky zero-seed / zero-state recovery flag
// Optional feature: define PRBS_LOCKUP_GUARD_EN to replace zero seeds with
// SEED and to recover from an all-zero LFSR state. Without it a zero seed
// is loaded as-is and lockup_err stays 0.
module prbs_share_arbiter
    import prbs_pkg::*;
#(
    parameter int               NREQ  = 4,
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    output logic             busy,
    output logic             lockup_err
);

    state_t             state;
    state_t             state_next;
    logic [2:0]         rr_ptr;
    logic [2:0]         rr_ptr_next;
    logic [NREQ-1:0]    gnt_next;
    logic [WIDTH-1:0]   data_next;
    logic               valid_next;
    logic               err_next;

    logic [WIDTH-1:0]   lfsr_q;
    logic               lfsr_load;
    logic [WIDTH-1:0]   lfsr_load_value;
    logic               lfsr_step;

    logic [MAX_REQ-1:0] req_ext;
    rr_pick_t           pick;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (lfsr_load),
        .load_value (lfsr_load_value),
        .step       (lfsr_step),
        .q          (lfsr_q)
    );

    assign busy = (state == INIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            rr_ptr     <= 3'(NREQ - 1);
            gnt        <= '0;
            rnd_data   <= '0;
            rnd_valid  <= 1'b0;
            lockup_err <= 1'b0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_ptr_next;
            gnt        <= gnt_next;
            rnd_data   <= data_next;
            rnd_valid  <= valid_next;
            lockup_err <= err_next;
        end
    end

    // Priority in IDLE: seed load, then (guarded build) zero-state recovery,
    // then a round-robin grant. rnd_data holds whenever no grant is issued.
    always_comb begin
        state_next      = state;
        rr_ptr_next     = rr_ptr;
        gnt_next        = '0;
        data_next       = rnd_data;
        valid_next      = 1'b0;
        err_next        = lockup_err;
        lfsr_load       = 1'b0;
        lfsr_load_value = seed_value;
        lfsr_step       = 1'b0;
        req_ext         = '0;
        req_ext[NREQ-1:0] = req;
        pick            = rr_search(req_ext, rr_ptr, NREQ);

        case (state)
            INIT: begin
                state_next = IDLE;
            end
            IDLE: begin
                if (seed_load) begin
                    lfsr_load = 1'b1;
`ifdef PRBS_LOCKUP_GUARD_EN
                    // A zero seed would lock the LFSR; substitute SEED
                    if (seed_value == '0) begin
                        lfsr_load_value = SEED;
                        err_next        = 1'b1;
                    end
`endif
                end
`ifdef PRBS_LOCKUP_GUARD_EN
                else if (lfsr_q == '0) begin
                    lfsr_load       = 1'b1;
                    lfsr_load_value = SEED;
                    err_next        = 1'b1;
                end
`endif
                else if (pick.found) begin
                    gnt_next    = NREQ'(1) << pick.idx;
                    data_next   = lfsr_q;
                    valid_next  = 1'b1;
                    lfsr_step   = 1'b1;
                    rr_ptr_next = pick.idx;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_prbs_share_arbiter.sv
// tb_prbs_share_arbiter
// Directed self-checking bench for prbs_share_arbiter with default
// parameters (NREQ=4, WIDTH=4, SEED=1000, TAPS=1100).
// Build with PRBS_LOCKUP_GUARD_EN defined to cover the guarded build.
module tb_prbs_share_arbiter;

    logic       clock;
    logic       reset;
    logic       seed_load;
    logic [3:0] seed_value;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] rnd_data;
    logic       rnd_valid;
    logic       busy;
    logic       lockup_err;

    int checks_total;
    int checks_passed;

    // Hand-derived default sequence: 1000 -> 0001 -> 0010 -> 0100 -> 1001 ...
    logic [3:0] seq [15] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
                             4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                             4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};

    prbs_share_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .req        (req),
        .gnt        (gnt),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .busy       (busy),
        .lockup_err (lockup_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle away from it
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reset, then walk through the INIT cycle so the arbiter is in IDLE
    task automatic do_reset;
        req        = 4'b0000;
        seed_load  = 1'b0;
        seed_value = 4'b0000;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        req        = 4'b0000;
        seed_load  = 1'b0;
        seed_value = 4'b0000;
        reset      = 1'b1;
        tick();
        checks_total++;
        if ({busy, rnd_valid, gnt, rnd_data, lockup_err} !== {1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0})
            $display("[TB] FAIL reset_state: busy/valid/gnt/data/err got %b %b %b %b %b required 1 0 0000 0000 0",
                     busy, rnd_valid, gnt, rnd_data, lockup_err);
        else checks_passed++;
        reset = 1'b0;
        req   = 4'b0001;
        tick();
        checks_total++;
        if ({busy, gnt} !== {1'b0, 4'b0000})
            $display("[TB] FAIL init_exit: busy/gnt got %b %b required 0 0000", busy, gnt);
        else checks_passed++;
    endtask

    // Continues from test_reset with req=0001 held, then an idle gap
    task automatic test_single;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks_total++;
            if ({rnd_valid, gnt, rnd_data} !== {1'b1, 4'b0001, seq[k]})
                $display("[TB] FAIL single_%0d: valid/gnt/data got %b %b %b required 1 0001 %b",
                         k, rnd_valid, gnt, rnd_data, seq[k]);
            else checks_passed++;
        end
        req = 4'b0000;
        tick();
        checks_total++;
        if ({rnd_valid, gnt, rnd_data} !== {1'b0, 4'b0000, 4'b0100})
            $display("[TB] FAIL idle_hold: valid/gnt/data got %b %b %b required 0 0000 0100",
                     rnd_valid, gnt, rnd_data);
        else checks_passed++;
        req = 4'b0001;
        tick();
        checks_total++;
        if ({rnd_valid, gnt, rnd_data} !== {1'b1, 4'b0001, 4'b1001})
            $display("[TB] FAIL after_idle: valid/gnt/data got %b %b %b required 1 0001 1001",
                     rnd_valid, gnt, rnd_data);
        else checks_passed++;
    endtask

    task automatic test_round_robin;
        logic [15:0] seen;
        logic [3:0]  exp_gnt;
        seen = '0;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_gnt = 4'b0001 << (k % 4);
            checks_total++;
            if ({rnd_valid, gnt, rnd_data} !== {1'b1, exp_gnt, seq[k % 15]})
                $display("[TB] FAIL rr_%0d: valid/gnt/data got %b %b %b required 1 %b %b",
                         k, rnd_valid, gnt, rnd_data, exp_gnt, seq[k % 15]);
            else checks_passed++;
            if (k < 15) seen[rnd_data] = 1'b1;
        end
        checks_total++;
        if (seen !== 16'hFFFE)
            $display("[TB] FAIL rr_coverage: words seen got %h required fffe", seen);
        else checks_passed++;
    endtask

    task automatic test_partial;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_gnt = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            checks_total++;
            if ({gnt, rnd_data} !== {exp_gnt, seq[k]})
                $display("[TB] FAIL alt_%0d: gnt/data got %b %b required %b %b",
                         k, gnt, rnd_data, exp_gnt, seq[k]);
            else checks_passed++;
        end
        req = 4'b0100;
        for (int k = 4; k < 7; k++) begin
            tick();
            checks_total++;
            if ({rnd_valid, gnt, rnd_data} !== {1'b1, 4'b0100, seq[k]})
                $display("[TB] FAIL solo_%0d: valid/gnt/data got %b %b %b required 1 0100 %b",
                         k, rnd_valid, gnt, rnd_data, seq[k]);
            else checks_passed++;
        end
    endtask

    task automatic test_seed_load;
        do_reset();
        req = 4'b1111;
        tick();
        checks_total++;
        if ({gnt, rnd_data} !== {4'b0001, 4'b1000})
            $display("[TB] FAIL seed_pre: gnt/data got %b %b required 0001 1000", gnt, rnd_data);
        else checks_passed++;
        seed_load  = 1'b1;
        seed_value = 4'b0011;
        tick();
        checks_total++;
        if ({rnd_valid, gnt, rnd_data} !== {1'b0, 4'b0000, 4'b1000})
            $display("[TB] FAIL seed_nogrant: valid/gnt/data got %b %b %b required 0 0000 1000",
                     rnd_valid, gnt, rnd_data);
        else checks_passed++;
        seed_load = 1'b0;
        tick();
        checks_total++;
        if ({gnt, rnd_data} !== {4'b0010, 4'b0011})
            $display("[TB] FAIL seed_first: gnt/data got %b %b required 0010 0011", gnt, rnd_data);
        else checks_passed++;
        tick();
        checks_total++;
        if ({gnt, rnd_data} !== {4'b0100, 4'b0110})
            $display("[TB] FAIL seed_second: gnt/data got %b %b required 0100 0110", gnt, rnd_data);
        else checks_passed++;
    endtask

    task automatic test_zero_seed;
        logic       exp_err;
        logic [3:0] exp_w0;
        logic [3:0] exp_w1;
`ifdef PRBS_LOCKUP_GUARD_EN
        exp_err = 1'b1;
        exp_w0  = 4'b1000;
        exp_w1  = 4'b0001;
`else
        exp_err = 1'b0;
        exp_w0  = 4'b0000;
        exp_w1  = 4'b0000;
`endif
        do_reset();
        req = 4'b0001;
        tick();
        seed_load  = 1'b1;
        seed_value = 4'b0000;
        tick();
        checks_total++;
        if ({gnt, lockup_err} !== {4'b0000, exp_err})
            $display("[TB] FAIL zero_seed_flag: gnt/err got %b %b required 0000 %b", gnt, lockup_err, exp_err);
        else checks_passed++;
        seed_load = 1'b0;
        tick();
        checks_total++;
        if ({rnd_valid, rnd_data, lockup_err} !== {1'b1, exp_w0, exp_err})
            $display("[TB] FAIL zero_seed_w0: valid/data/err got %b %b %b required 1 %b %b",
                     rnd_valid, rnd_data, lockup_err, exp_w0, exp_err);
        else checks_passed++;
        tick();
        checks_total++;
        if ({rnd_valid, rnd_data, lockup_err} !== {1'b1, exp_w1, exp_err})
            $display("[TB] FAIL zero_seed_w1: valid/data/err got %b %b %b required 1 %b %b",
                     rnd_valid, rnd_data, lockup_err, exp_w1, exp_err);
        else checks_passed++;
    endtask

    task automatic test_reset_midstream;
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks_total++;
        if ({busy, rnd_valid, gnt, rnd_data, lockup_err} !== {1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0})
            $display("[TB] FAIL mid_reset: busy/valid/gnt/data/err got %b %b %b %b %b required 1 0 0000 0000 0",
                     busy, rnd_valid, gnt, rnd_data, lockup_err);
        else checks_passed++;
        reset = 1'b0;
        tick();
        checks_total++;
        if ({busy, gnt} !== {1'b0, 4'b0000})
            $display("[TB] FAIL mid_init: busy/gnt got %b %b required 0 0000", busy, gnt);
        else checks_passed++;
        tick();
        checks_total++;
        if ({rnd_valid, gnt, rnd_data} !== {1'b1, 4'b0001, 4'b1000})
            $display("[TB] FAIL mid_first: valid/gnt/data got %b %b %b required 1 0001 1000",
                     rnd_valid, gnt, rnd_data);
        else checks_passed++;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset      = 1'b1;
        seed_load  = 1'b0;
        seed_value = 4'b0000;
        req        = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_partial();
        test_seed_load();
        test_zero_seed();
        test_reset_midstream();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
